// File: rtl/nibble_serial_cla_adder.sv
// nibble_serial_cla_adder: WIDTH-bit adder that walks the operands one nibble
// per clock through a single 4-bit carry-lookahead slice, carrying between
// steps through a 1-bit register. start/busy/done handshake.
// Optional feature: define ADDER_OVF_EN to add the signed-overflow port Ovf.

// 4-bit carry-lookahead slice: sum nibble plus the carries into bit 3 and out of bit 3.
module nibble_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c,
    output logic [3:0] s,
    output logic       c3,
    output logic       c4
);
    logic [3:0] g, p;
    logic       c1, c2;

    assign g  = a & b;
    assign p  = a ^ b;
    assign c1 = g[0] | (p[0] & c);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
    assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c);
    assign s  = p ^ {c3, c2, c1, c};
endmodule

module nibble_serial_cla_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
`ifdef ADDER_OVF_EN
    ,
    output logic             Ovf
`endif
);
    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic [WIDTH-1:0] s_ext, res_nxt;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [3:0]       nib_s;
    logic             nib_c3, nib_c4;
    logic             accept, last;

    // Operands are shifted right each step, so the slice always sees nibble 0.
    nibble_cla4 u_slice (
        .a  (a_q[3:0]),
        .b  (b_q[3:0]),
        .c  (carry),
        .s  (nib_s),
        .c3 (nib_c3),
        .c4 (nib_c4)
    );

    assign last = (idx == IW'(N - 1));

    // Next-state logic; start is only honoured outside RUN.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: if (start) begin
                accept    = 1'b1;
                state_nxt = RUN;
            end
            RUN:  if (last) state_nxt = DONE;
            DONE: if (start) begin
                accept    = 1'b1;
                state_nxt = RUN;
            end else begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Result fills from the top: after N shifts nibble i lands at bits 4i+3:4i.
    always_comb begin
        s_ext      = '0;
        s_ext[3:0] = nib_s;
        res_nxt    = (res_q >> 4) | (s_ext << (WIDTH - 4));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Datapath, handshake flags and output registers; outputs load only on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            idx   <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            Sum   <= '0;
            Cout  <= 1'b0;
`ifdef ADDER_OVF_EN
            Ovf   <= 1'b0;
`endif
        end else begin
            busy <= (state_nxt == RUN);
            done <= (state_nxt == DONE);
            if (accept) begin
                a_q   <= A;
                b_q   <= B;
                carry <= Cin;
                idx   <= '0;
            end else if (state == RUN) begin
                a_q   <= a_q >> 4;
                b_q   <= b_q >> 4;
                res_q <= res_nxt;
                carry <= nib_c4;
                idx   <= idx + 1'b1;
                if (last) begin
                    Sum  <= res_nxt;
                    Cout <= nib_c4;
`ifdef ADDER_OVF_EN
                    // carry into the MSB differs from carry out of it
                    Ovf  <= nib_c3 ^ nib_c4;
`endif
                end
            end
        end
    end

`ifndef ADDER_OVF_EN
    // Carry into the MSB is only needed for overflow.
    logic unused_c3;
    assign unused_c3 = nib_c3;
`endif
endmodule

// File: tb/tb_nibble_serial_cla_adder.sv
// Bench for nibble_serial_cla_adder (WIDTH=16): directed vectors, a cycle
// model built from plain arithmetic and a countdown, checked every cycle.
module tb_nibble_serial_cla_adder;
    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         Cin = 1'b0;
    logic [W-1:0] A = '0, B = '0;
    logic         busy, done, Cout;
    logic [W-1:0] Sum;
`ifdef ADDER_OVF_EN
    logic         Ovf;
`endif

    nibble_serial_cla_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
        .Cout  (Cout)
`ifdef ADDER_OVF_EN
        ,
        .Ovf   (Ovf)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: an accepted start books a result N cycles ahead.
    int           rem = 0;
    logic [W:0]   t_full;
    logic [W-1:0] p_sum = '0, e_sum = '0;
    logic         p_cout = 0, e_cout = 0, p_ovf = 0, e_ovf = 0, e_done = 0;

    always @(posedge clk) begin
        if (rst) begin
            rem = 0; e_done = 0; e_sum = '0; e_cout = 0; e_ovf = 0;
        end else if (rem != 0) begin
            rem--;
            e_done = (rem == 0);
            if (rem == 0) begin
                e_sum = p_sum; e_cout = p_cout; e_ovf = p_ovf;
            end
        end else begin
            e_done = 0;
            if (start) begin
                t_full = A + B + Cin;
                p_sum  = t_full[W-1:0];
                p_cout = t_full[W];
                p_ovf  = (A[W-1] == B[W-1]) && (t_full[W-1] != A[W-1]);
                rem    = N;
            end
        end
    end

    // Compare DUT against the model every cycle, just after the edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        chk("busy", busy, rem != 0);
        chk("done", done, e_done);
        chk("sum", Sum, e_sum);
        chk("cout", Cout, e_cout);
        chk("busy_and_done", busy & done, 0);
`ifdef ADDER_OVF_EN
        chk("ovf", Ovf, e_ovf);
`endif
        if (done) done_cnt++;
    end

    task automatic wait_done(output int t);
        bit got = 0;
        t = -1;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                t = cyc;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL wait_done: no done within 30 cycles (cycle %0d)", cyc);
        end
    endtask

    task automatic check_result(input string nm, input logic [W-1:0] es, input logic ec, input logic eo);
        chk({nm, "_sum"}, Sum, es);
        chk({nm, "_cout"}, Cout, ec);
`ifdef ADDER_OVF_EN
        chk({nm, "_ovf"}, Ovf, eo);
`else
        if (eo === 1'bx) $display("unreachable");
`endif
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                      input logic [W-1:0] es, input logic ec, input logic eo, input string nm);
        int t0, t1;
        @(negedge clk);
        A = a; B = b; Cin = c; start = 1;
        t0 = cyc;
        @(negedge clk);
        start = 0;
        wait_done(t1);
        chk({nm, "_latency"}, t1 - t0, N + 1);
        check_result(nm, es, ec, eo);
    endtask

    initial begin
        int t1, t2, d0;
        repeat (3) @(negedge clk);
        chk("reset_sum", Sum, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        rst = 0;
        @(negedge clk);

        op(16'h1234, 16'h4321, 0, 16'h5555, 0, 0, "basic");
        op(16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0, "ripple_all");
        op(16'h7FFF, 16'h0000, 1, 16'h8000, 0, 1, "cin_ovf");
        op(16'h8000, 16'h8000, 0, 16'h0000, 1, 1, "neg_ovf");
        op(16'hABCD, 16'h1234, 1, 16'hBE02, 0, 0, "mixed");

        // start during RUN is dropped
        d0 = done_cnt;
        @(negedge clk); A = 16'h1111; B = 16'h2222; Cin = 0; start = 1;
        @(negedge clk); start = 0;
        @(negedge clk); A = 16'hAAAA; B = 16'h5555; Cin = 1; start = 1;
        @(negedge clk); start = 0;
        wait_done(t1);
        check_result("ignore", 16'h3333, 0, 0);
        repeat (8) @(negedge clk);
        chk("ignore_one_done", done_cnt - d0, 1);

        // start held through DONE launches back-to-back
        @(negedge clk); A = 16'h1234; B = 16'h4321; Cin = 0; start = 1;
        @(negedge clk); A = 16'h00FF; B = 16'h0F01;
        wait_done(t1);
        check_result("hold_first", 16'h5555, 0, 0);
        @(negedge clk); start = 0;
        wait_done(t2);
        chk("hold_spacing", t2 - t1, N + 1);
        check_result("hold_second", 16'h1000, 0, 0);

        // reset in the third RUN cycle aborts with no done
        d0 = done_cnt;
        @(negedge clk); A = 16'hFFFF; B = 16'hFFFF; Cin = 1; start = 1;
        @(negedge clk); start = 0;
        @(negedge clk);
        @(negedge clk); rst = 1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_sum", Sum, 0);
        chk("abort_cout", Cout, 0);
        rst = 0;
        repeat (8) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
